// File: rtl/pieo_datatypes.sv
// Shared element layout, FSM state encoding and field-width constants for the PIEO sublist.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pieo_datatypes;

    localparam int ELEM_RANK_W      = 4;
    localparam int ELEM_ID_W        = 3;
    localparam int ELEM_TIME_W      = 8;
    localparam int ELEM_PAYLOAD_W   = 8;
    localparam int ELEM_NULL_BUCKET = 7;
    localparam int ELEM_W           = ELEM_RANK_W + ELEM_ID_W + ELEM_PAYLOAD_W;

    // One queue element; rank is the sort key, send_time selects the eligibility bit.
    typedef struct packed {
        logic [ELEM_RANK_W-1:0]    rank;
        logic [ELEM_ID_W-1:0]      send_time;
        logic [ELEM_PAYLOAD_W-1:0] payload;
    } elem_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INS_SHIFT  = 2'd1,
        EXT_SEARCH = 2'd2,
        EXT_SHIFT  = 2'd3
    } state_t;

    // Empty slot: largest rank so it sorts last, null bucket so it is never eligible.
    function automatic elem_t empty_elem();
        elem_t e;
        e.rank      = '1;
        e.send_time = ELEM_ID_W'(ELEM_NULL_BUCKET);
        e.payload   = '0;
        return e;
    endfunction

endpackage

// File: rtl/pieo_priority_encoder.sv
// Lowest-set-bit priority encoder: returns index of the first asserted request and a found flag.
// Latency: purely combinational.
// Backpressure: none.
module pieo_priority_encoder #(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx   = '0;
        found = |req;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pieo_sublist_engine.sv
// Rank-sorted PIEO sublist: sorted insert, extract of the lowest-ranked eligible element.
// Latency: enqueue visible 2 cycles after accept; extract done pulse 3 cycles after request.
// Backpressure: enq_ready low outside IDLE, when full, or when a dequeue is requested.
module pieo_sublist_engine
    import pieo_datatypes::*;
#(
    parameter int DEPTH       = 8,
    parameter int RANK_LOG    = ELEM_RANK_W,
    parameter int ID_LOG      = ELEM_ID_W,
    parameter int TIME_LOG    = ELEM_TIME_W,
    parameter int PAYLOAD_W   = ELEM_PAYLOAD_W,
    parameter int NULL_BUCKET = ELEM_NULL_BUCKET
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enq_valid,
    output logic                              enq_ready,
    input  logic [RANK_LOG+ID_LOG+PAYLOAD_W-1:0] enq_elem,
    input  logic                              deq_valid,
    input  logic [TIME_LOG-1:0]               curr_time_in,
    output logic                              deq_done,
    output logic                              deq_found,
    output logic [RANK_LOG+ID_LOG+PAYLOAD_W-1:0] deq_elem,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              full,
    output logic                              empty
);

    // The element struct is sized by the package; the width parameters here must match it.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // The null bucket is stripped when latching so an empty slot can never look eligible.
    localparam logic [TIME_LOG-1:0] NULL_MASK =
        (NULL_BUCKET < TIME_LOG) ? (TIME_LOG'(1) << NULL_BUCKET) : '0;

    state_t              state;
    state_t              state_nxt;
    elem_t               slots [DEPTH];
    elem_t               new_elem;
    logic [TIME_LOG-1:0] time_lat;
    logic [IW-1:0]       ext_idx;
    logic                miss_pend;
    logic [CW-1:0]       count_nxt;

    logic                enq_fire;
    logic                deq_start;

    logic [DEPTH-1:0]    ins_req;
    logic [IW-1:0]       ins_idx;
    logic                ins_found;
    logic [DEPTH-1:0]    elig_req;
    logic [IW-1:0]       elig_idx;
    logic                elig_found;

    // Insert position: first empty slot or first slot ranked strictly above the new element,
    // which keeps equal ranks in arrival order.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ins_req[i] = (i >= int'(count)) || (slots[i].rank > new_elem.rank);
        end
    end

    // Eligibility: occupied slot whose bucket is in range and set in the latched bitmap.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig_req[i] = (i < int'(count))
                       && (int'(slots[i].send_time) < TIME_LOG)
                       && time_lat[slots[i].send_time];
        end
    end

    pieo_priority_encoder #(
        .W  (DEPTH),
        .IW (IW)
    ) u_ins_enc (
        .req   (ins_req),
        .idx   (ins_idx),
        .found (ins_found)
    );

    pieo_priority_encoder #(
        .W  (DEPTH),
        .IW (IW)
    ) u_elig_enc (
        .req   (elig_req),
        .idx   (elig_idx),
        .found (elig_found)
    );

    // Next-state and handshake decode; dequeue requests take priority over enqueue in IDLE.
    always_comb begin
        state_nxt = state;
        enq_ready = 1'b0;
        enq_fire  = 1'b0;
        deq_start = 1'b0;
        case (state)
            IDLE: begin
                enq_ready = !full && !deq_valid;
                enq_fire  = enq_ready && enq_valid;
                deq_start = deq_valid;
                if (deq_valid) begin
                    state_nxt = EXT_SEARCH;
                end else if (enq_fire) begin
                    state_nxt = INS_SHIFT;
                end
            end
            INS_SHIFT:  state_nxt = IDLE;
            EXT_SEARCH: state_nxt = elig_found ? EXT_SHIFT : IDLE;
            EXT_SHIFT:  state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Occupancy follows the cycle in which a shift actually completes.
    always_comb begin
        count_nxt = count;
        if (state == INS_SHIFT && ins_found) begin
            count_nxt = count + CW'(1);
        end else if (state == EXT_SHIFT) begin
            count_nxt = count - CW'(1);
        end
    end

    // Control, latched request context and extract result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            new_elem  <= empty_elem();
            time_lat  <= '0;
            ext_idx   <= '0;
            miss_pend <= 1'b0;
            deq_done  <= 1'b0;
            deq_found <= 1'b0;
            deq_elem  <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            state <= state_nxt;
            if (enq_fire) begin
                new_elem <= elem_t'(enq_elem);
            end
            if (deq_start) begin
                time_lat <= curr_time_in & ~NULL_MASK;
            end
            if (state == EXT_SEARCH) begin
                ext_idx <= elig_idx;
            end
            // A miss is held one extra cycle so its done pulse lines up with the hit case.
            miss_pend <= (state == EXT_SEARCH) && !elig_found;
            deq_done  <= miss_pend || (state == EXT_SHIFT);
            deq_found <= (state == EXT_SHIFT);
            deq_elem  <= (state == EXT_SHIFT) ? slots[ext_idx] : '0;
            count     <= count_nxt;
            full      <= (count_nxt == CW'(DEPTH));
            empty     <= (count_nxt == '0);
        end
    end

    // Slot array: shift up from the insert point, or shift down over the extracted slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= empty_elem();
            end
        end else if (state == INS_SHIFT && ins_found) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (i > int'(ins_idx)) begin
                    slots[i] <= slots[i-1];
                end else if (i == int'(ins_idx)) begin
                    slots[i] <= new_elem;
                end
            end
            if (ins_idx == '0) begin
                slots[0] <= new_elem;
            end
        end else if (state == EXT_SHIFT) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(ext_idx)) begin
                    slots[i] <= slots[i+1];
                end
            end
            slots[DEPTH-1] <= empty_elem();
        end
    end

endmodule

// File: tb/tb_pieo_sublist_engine.sv
// Self-checking bench for pieo_sublist_engine against a sorted-queue reference model.
// Latency: checks 2-cycle enqueue visibility and 3-cycle extract completion.
// Backpressure: exercises full-queue hold-off and dequeue-over-enqueue priority.
module tb_pieo_sublist_engine;

    localparam int DEPTH       = 8;
    localparam int TIME_LOG    = 8;
    localparam int NULL_BUCKET = 7;
    localparam int EW          = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [EW-1:0] enq_elem = '0;
    logic          deq_valid = 1'b0;
    logic [7:0]    curr_time_in = '0;
    logic          deq_done;
    logic          deq_found;
    logic [EW-1:0] deq_elem;
    logic [3:0]    count;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;

    // Reference model: elements in service order (rank ascending, ties by arrival).
    logic [EW-1:0] mq[$];

    always #5 clk = ~clk;

    pieo_sublist_engine dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_elem     (enq_elem),
        .deq_valid    (deq_valid),
        .curr_time_in (curr_time_in),
        .deq_done     (deq_done),
        .deq_found    (deq_found),
        .deq_elem     (deq_elem),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    // Count accepted enqueue handshakes.
    always @(posedge clk) begin
        if (enq_valid && enq_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int r, input int st, input int pl);
        return {r[3:0], st[2:0], pl[7:0]};
    endfunction

    task automatic model_ins(input logic [EW-1:0] e);
        int pos;
        pos = mq.size();
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i][14:11] > e[14:11]) pos = i;
        end
        mq.insert(pos, e);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
        chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    endtask

    // Wait for a pending enqueue (enq_valid already high) to be taken, then verify occupancy.
    task automatic wait_enq(input logic [EW-1:0] e, input int a0);
        int n;
        n = 0;
        while (acc_cnt == a0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        enq_valid = 1'b0;
        chk("enq_accept", 32'(acc_cnt - a0), 32'd1);
        if (acc_cnt != a0) begin
            model_ins(e);
            @(posedge clk); #1;
            check_status("enq");
        end
    endtask

    task automatic do_enq(input logic [EW-1:0] e);
        int a0;
        a0 = acc_cnt;
        @(negedge clk);
        enq_valid = 1'b1;
        enq_elem  = e;
        wait_enq(e, a0);
    endtask

    task automatic do_deq(input logic [7:0] bitmap, input bit with_enq, input logic [EW-1:0] e);
        bit            has;
        int            idx;
        int            st;
        int            lat;
        int            a0;
        logic [EW-1:0] exp_e;
        has = 1'b0;
        idx = 0;
        exp_e = '0;
        for (int i = 0; i < mq.size(); i++) begin
            st = int'(mq[i][10:8]);
            if (!has && st != NULL_BUCKET && st < TIME_LOG && bitmap[st]) begin
                has = 1'b1;
                idx = i;
                exp_e = mq[i];
            end
        end
        a0 = acc_cnt;
        @(negedge clk);
        deq_valid    = 1'b1;
        curr_time_in = bitmap;
        if (with_enq) begin
            enq_valid = 1'b1;
            enq_elem  = e;
            #1;
            chk("enq_ready_vs_deq", 32'(enq_ready), 32'd0);
        end
        @(posedge clk); #1;
        deq_valid    = 1'b0;
        curr_time_in = 8'($urandom) & 8'h7f;
        lat = 1;
        while (!deq_done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("deq_lat", 32'(lat), 32'd3);
        chk("deq_found", 32'(deq_found), 32'(has));
        chk("deq_elem", 32'(deq_elem), 32'(exp_e));
        if (has) mq.delete(idx);
        check_status("deq");
        if (with_enq) begin
            chk("enq_held_during_deq", 32'(acc_cnt - a0), 32'd0);
            wait_enq(e, a0);
        end
    endtask

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_deq_done", 32'(deq_done), 32'd0);
        chk("rst_deq_found", 32'(deq_found), 32'd0);
        chk("rst_deq_elem", 32'(deq_elem), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);

        // Empty queue extract.
        do_deq(8'h7f, 1'b0, '0);

        // Sorted insert with ties: 5,2,9,2 -> 2,2,5,9.
        do_enq(mk(5, 0, 8'h11));
        do_enq(mk(2, 0, 8'h22));
        do_enq(mk(9, 0, 8'h33));
        do_enq(mk(2, 0, 8'h44));
        chk("order_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) do_deq(8'h01, 1'b0, '0);

        // Eligibility selects past a lower rank.
        do_enq(mk(1, 4, 8'hA1));
        do_enq(mk(3, 1, 8'hA3));
        do_deq(8'b0000_0010, 1'b0, '0);
        do_deq(8'h00, 1'b0, '0);
        do_deq(8'b0001_0000, 1'b0, '0);

        // Fill, hold a ninth enqueue, release it through a dequeue.
        for (int i = 0; i < DEPTH; i++) do_enq(mk(i % 4, i % 7, i));
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        begin
            int a0;
            a0 = acc_cnt;
            @(negedge clk);
            enq_valid = 1'b1;
            enq_elem  = mk(0, 2, 8'h99);
            repeat (4) @(negedge clk);
            chk("full_no_accept", 32'(acc_cnt - a0), 32'd0);
            chk("full_count_hold", 32'(count), 32'd8);
        end
        do_deq(8'h08, 1'b1, mk(0, 2, 8'h99));

        // Reset while the extract shift is in progress.
        @(negedge clk);
        deq_valid    = 1'b1;
        curr_time_in = 8'h7f;
        @(posedge clk); #1;
        deq_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        mq.delete();
        chk("mid_rst_deq_done", 32'(deq_done), 32'd0);
        chk("mid_rst_deq_elem", 32'(deq_elem), 32'd0);
        check_status("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_done", 32'(deq_done), 32'd0);
        end
        chk("post_rst_enq_ready", 32'(enq_ready), 32'd1);
        do_deq(8'h7f, 1'b0, '0);

        // Randomized mix against the model.
        for (int it = 0; it < 300; it++) begin
            if (mq.size() < DEPTH && $urandom_range(0, 99) < 55) begin
                do_enq(mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 255)));
            end else if ($urandom_range(0, 9) == 0) begin
                do_deq(8'h00, 1'b0, '0);
            end else begin
                do_deq(8'($urandom) & 8'h7f, 1'b0, '0);
            end
        end

        // Drain whatever is extractable.
        guard = 0;
        while (mq.size() > 0 && guard < 12) begin
            do_deq(8'h7f, 1'b0, '0);
            guard++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pieo_sublist_engine.md
PIEO_SUBLIST_ENGINE -- requirements
Module: pieo_sublist_engine

Interface
REQ-001 Clocking SHALL be one clock, clk; reset, rst, SHALL be asynchronous and active-high.
REQ-002 Parameter DEPTH, 8, number of element slots (>=2).
REQ-003 Parameter RANK_LOG, 4, rank field width.
REQ-004 Parameter ID_LOG, 3, send_time (bucket ID) field width.
REQ-005 Parameter TIME_LOG, 8, eligibility bitmap width (=2**ID_LOG).
REQ-006 Parameter PAYLOAD_W, 8, opaque payload width.
REQ-007 Parameter NULL_BUCKET, 7, bucket ID marking an empty slot; its bit SHALL never be set in curr_time_in.
REQ-008 clk  in  1  clock.
REQ-009 rst  in  1  async active-high reset.
REQ-010 enq_valid  in  1  enqueue request.
REQ-011 enq_ready  out  1  enqueue accepted when high with enq_valid.
REQ-012 enq_elem  in  RANK_LOG+ID_LOG+PAYLOAD_W  {rank, send_time, payload}.
REQ-013 deq_valid  in  1  extract request, single-cycle pulse, sampled only when in IDLE.
REQ-014 curr_time_in  in  TIME_LOG  eligibility bitmap; bit b set = bucket b eligible.
REQ-015 deq_done  out  1  one-cycle extract completion pulse.
REQ-016 deq_found  out  1  valid with deq_done; 1 = element returned.
REQ-017 deq_elem  out  RANK_LOG+ID_LOG+PAYLOAD_W  extracted element, valid with deq_done && deq_found.
REQ-018 count  out  $clog2(DEPTH+1)  occupied slots.
REQ-019 full / empty  out  1 each  count==DEPTH / count==0.

Function
REQ-020 Slots SHALL stay sorted ascending by rank, slot 0 = head; equal ranks SHALL keep arrival (FIFO) order.
REQ-021 FSM states SHALL be IDLE, INS_SHIFT, EXT_SEARCH, EXT_SHIFT.
REQ-022 enq_ready SHALL equal (state==IDLE) && !full && !deq_valid; dequeue wins simultaneous requests.
REQ-023 Accepted enqueue: IDLE->INS_SHIFT; insert position = first slot whose rank > new rank (or first empty slot); slots from that position shift up by one; returns to IDLE; count increments; element visible after 2 cycles.
REQ-024 deq_valid in IDLE: latch curr_time_in, ->EXT_SEARCH; find lowest slot i with curr_time_latched[send_time_i]==1 and slot non-empty.
REQ-025 Eligible element found: ->EXT_SHIFT; slots above i shift down; top slot becomes empty; count decrements; deq_done=1, deq_found=1, deq_elem=slot i, cycle after EXT_SHIFT entry; ->IDLE.
REQ-026 No eligible element or empty: EXT_SEARCH->IDLE with deq_done=1, deq_found=0, deq_elem=0, contents unchanged; latency identical to found case (3 cycles request to done).
REQ-027 Empty slot SHALL hold rank all-ones, send_time=NULL_BUCKET, payload 0, and SHALL never be eligible.
REQ-028 send_time >= TIME_LOG SHALL be treated ineligible.
REQ-029 deq_valid outside IDLE SHALL be ignored; enq_valid while enq_ready low SHALL not be consumed.
REQ-030 count/full/empty SHALL be registered, updated on the cycle the shift completes.

Reset
REQ-031 On rst: all slots empty per REQ-027, state IDLE, count 0, empty=1, full=0, deq_done=0, deq_found=0, deq_elem=0; enq_ready=1 first cycle after release.
REQ-032 rst mid-operation SHALL abort with no deq_done pulse and no partial shift retained.

Structure
REQ-033 Element struct, FSM state enum and NULL_BUCKET/width constants SHALL live in pieo_datatypes.
REQ-034 Eligible-slot search SHALL be a sub-module pieo_priority_encoder (DEPTH-wide lowest-set-bit, outputs index and found).

Verification
REQ-035 Enqueue ranks 5,2,9,2 (send_time 0) -> slot order 2(first),2(second),5,9; count=4.
REQ-036 Fill DEPTH=8 -> full=1, enq_ready=0; 9th enq_valid held -> accepted only after a successful dequeue.
REQ-037 Slots ranks 1,3 with send_time 4,1; curr_time_in=8'b0000_0010 -> deq_found=1, returns rank 3, remaining rank 1, deq_done 3 cycles after request.
REQ-038 Empty queue or curr_time_in=0 -> deq_done=1, deq_found=0, count unchanged.
REQ-039 enq_valid and deq_valid same IDLE cycle -> dequeue executes, enq_ready=0, enqueue accepted on next IDLE.
REQ-040 rst asserted during EXT_SHIFT -> no deq_done, count=0, all outputs at reset values.
